mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one simple_memory request port among NUM_PORTS cache controllers.
// Optional feature: define ARB_TIMEOUT_EN to abort a stalled transaction after 15 BUSY cycles.
module mem_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] addr_i,
  input  logic [NUM_PORTS*DATA_W-1:0] wdata_i,
  input  logic [NUM_PORTS-1:0]        we_i,
  output logic [NUM_PORTS-1:0]        gnt_o,
  output logic [NUM_PORTS-1:0]        done_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        err_o,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_we,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ready
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]         winner_q, winner_d;
  logic [NUM_PORTS-1:0]  gnt_q, gnt_d;
  logic [NUM_PORTS-1:0]  done_q, done_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;

  logic                  pick_found;
  logic [PW-1:0]         pick_idx;
  logic [PW-1:0]         cand;

`ifdef ARB_TIMEOUT_EN
  logic [3:0]            tmo_q, tmo_d;
  logic                  err_q, err_d;
`endif

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] w);
    if (int'(w) == NUM_PORTS - 1) return '0;
    return w + PW'(1);
  endfunction

  // First requesting port at or above rr_ptr, wrapping past the top port.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = PW'((int'(rr_ptr_q) + i) % NUM_PORTS);
      if (!pick_found && req_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    winner_d    = winner_q;
    gnt_d       = gnt_q;
    done_d      = '0;
    rdata_d     = rdata_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
`ifdef ARB_TIMEOUT_EN
    tmo_d       = tmo_q;
    err_d       = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          winner_d        = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
          mem_req_d       = 1'b1;
          mem_addr_d      = addr_i[pick_idx*ADDR_W +: ADDR_W];
          mem_wdata_d     = wdata_i[pick_idx*DATA_W +: DATA_W];
          mem_we_d        = we_i[pick_idx];
          state_d         = BUSY;
`ifdef ARB_TIMEOUT_EN
          tmo_d           = '0;
`endif
        end
      end

      BUSY: begin
        if (mem_ready) begin
          mem_req_d        = 1'b0;
          gnt_d            = '0;
          rdata_d          = mem_rdata;
          done_d[winner_q] = 1'b1;
          rr_ptr_d         = next_ptr(winner_q);
          state_d          = DONE;
        end
`ifdef ARB_TIMEOUT_EN
        else begin
          tmo_d = tmo_q + 4'd1;
          // Give up once the counter reaches 15; the requester sees an error completion.
          if (tmo_d == 4'd15) begin
            mem_req_d        = 1'b0;
            gnt_d            = '0;
            rdata_d          = '0;
            done_d[winner_q] = 1'b1;
            err_d            = 1'b1;
            rr_ptr_d         = next_ptr(winner_q);
            state_d          = DONE;
          end
        end
`endif
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      winner_q    <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      winner_q    <= winner_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
`ifdef ARB_TIMEOUT_EN
      tmo_q       <= tmo_d;
      err_q       <= err_d;
`endif
    end
  end

  assign gnt_o     = gnt_q;
  assign done_o    = done_q;
  assign rdata_o   = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
`ifdef ARB_TIMEOUT_EN
  assign err_o     = err_q;
`else
  assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural simple_memory (word-addressed, mem[i]=i after reset).
// Expected grants/completions are queued by the stimulus and checked by an independent monitor.
module tb_mem_arbiter;

  localparam int NP = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP-1:0]    req_i;
  logic [NP*32-1:0] addr_i;
  logic [NP*32-1:0] wdata_i;
  logic [NP-1:0]    we_i;
  logic [NP-1:0]    gnt_o;
  logic [NP-1:0]    done_o;
  logic [31:0]      rdata_o;
  logic             err_o;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_we;
  logic [31:0]      mem_rdata = '0;
  logic             mem_ready = 1'b0;

  logic             tbReq   [NP];
  logic [31:0]      tbAddr  [NP];
  logic [31:0]      tbWdata [NP];
  logic             tbWe    [NP];

  logic [31:0]      memArr [0:255];
  int               memCnt = 0;
  logic             memStall = 1'b0;

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t expQ[$];
  int   vecCount  = 0;
  int   failCount = 0;
  int   cycle     = 0;
  int   grantCycle = 0;
  logic [NP-1:0] prevGnt = '0;

  mem_arbiter #(.NUM_PORTS(NP), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .we_i(we_i), .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_i   = '0;
    we_i    = '0;
    addr_i  = '0;
    wdata_i = '0;
    for (int p = 0; p < NP; p++) begin
      req_i[p]             = tbReq[p];
      we_i[p]              = tbWe[p];
      addr_i[p*32 +: 32]   = tbAddr[p];
      wdata_i[p*32 +: 32]  = tbWdata[p];
    end
  end

  // Memory model: mem_ready rises four edges after it first sees mem_req, for one cycle.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) memArr[i] <= 32'(i);
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      memCnt    <= 0;
    end else if (mem_req && !mem_ready && !memStall) begin
      if (memCnt == 3) begin
        mem_ready <= 1'b1;
        memCnt    <= 0;
        if (mem_we) begin
          memArr[mem_addr[9:2]] <= mem_wdata;
          mem_rdata <= '0;
        end else begin
          mem_rdata <= memArr[mem_addr[9:2]];
        end
      end else begin
        memCnt <= memCnt + 1;
      end
    end else begin
      mem_ready <= 1'b0;
      memCnt    <= 0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    vecCount++;
    if (act !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, expv, cycle);
    end
  endtask

  task automatic pushExp(input int p, input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [31:0] rd, input logic e, input int lat);
    exp_t x;
    x.port = p; x.addr = a; x.we = w; x.wdata = d; x.rdata = rd; x.err = e; x.lat = lat;
    expQ.push_back(x);
  endtask

  // Requester behaviour: hold req until done is seen, then drop it and idle one cycle.
  task automatic applyStimulus(input int p, input logic [31:0] a, input logic w, input logic [31:0] d);
    bit seen;
    seen = 1'b0;
    tbAddr[p]  = a;
    tbWdata[p] = d;
    tbWe[p]    = w;
    tbReq[p]   = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done_o[p]) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) checkOutput($sformatf("done_wait_port%0d", p), 64'd0, 64'd1);
    tbReq[p] = 1'b0;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: checks each grant against the queue head and pops it on completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cycle++;
      if (!rst) begin
        if (gnt_o != '0) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_grant", 64'(gnt_o), 64'd0);
          end else begin
            e = expQ[0];
            if (prevGnt == '0) grantCycle = cycle;
            checkOutput("gnt", 64'(gnt_o), 64'(4'b1 << e.port));
            checkOutput("mem_req_busy", 64'(mem_req), 64'd1);
            checkOutput("mem_addr", 64'(mem_addr), 64'(e.addr));
            checkOutput("mem_we", 64'(mem_we), 64'(e.we));
            checkOutput("mem_wdata", 64'(mem_wdata), 64'(e.wdata));
          end
        end
        if (done_o != '0) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_done", 64'(done_o), 64'd0);
          end else begin
            e = expQ.pop_front();
            checkOutput("done", 64'(done_o), 64'(4'b1 << e.port));
            checkOutput("rdata", 64'(rdata_o), 64'(e.rdata));
            checkOutput("err", 64'(err_o), 64'(e.err));
            checkOutput("latency", 64'(cycle - grantCycle), 64'(e.lat));
            checkOutput("mem_req_done", 64'(mem_req), 64'd0);
            checkOutput("gnt_done", 64'(gnt_o), 64'd0);
          end
        end
      end
      prevGnt = gnt_o;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit sawDone;
    for (int p = 0; p < NP; p++) begin
      tbReq[p] = 1'b0; tbAddr[p] = '0; tbWdata[p] = '0; tbWe[p] = 1'b0;
    end
    @(negedge clk);
    doReset();

    checkOutput("rst_gnt", 64'(gnt_o), 64'd0);
    checkOutput("rst_done", 64'(done_o), 64'd0);
    checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("rst_rdata", 64'(rdata_o), 64'd0);
    checkOutput("rst_err", 64'(err_o), 64'd0);

    $display("[TB] single read");
    pushExp(0, 32'h10, 1'b0, 32'h0, 32'h4, 1'b0, 5);
    applyStimulus(0, 32'h10, 1'b0, 32'h0);

    $display("[TB] write then read");
    pushExp(2, 32'h20, 1'b1, 32'hDEADBEEF, 32'h0, 1'b0, 5);
    applyStimulus(2, 32'h20, 1'b1, 32'hDEADBEEF);
    pushExp(2, 32'h20, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 5);
    applyStimulus(2, 32'h20, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("rdata_hold", 64'(rdata_o), 64'hDEADBEEF);

    $display("[TB] simultaneous requests");
    doReset();
    for (int p = 0; p < NP; p++) pushExp(p, 32'h40 + 32'(4*p), 1'b0, 32'h0, 32'h10 + 32'(p), 1'b0, 5);
    fork
      applyStimulus(0, 32'h40, 1'b0, 32'h0);
      applyStimulus(1, 32'h44, 1'b0, 32'h0);
      applyStimulus(2, 32'h48, 1'b0, 32'h0);
      applyStimulus(3, 32'h4C, 1'b0, 32'h0);
    join

    $display("[TB] fairness ports 1 and 3");
    doReset();
    pushExp(1, 32'h80, 1'b0, 32'h0, 32'h20, 1'b0, 5);
    pushExp(3, 32'hC0, 1'b0, 32'h0, 32'h30, 1'b0, 5);
    pushExp(1, 32'h84, 1'b0, 32'h0, 32'h21, 1'b0, 5);
    pushExp(3, 32'hC4, 1'b0, 32'h0, 32'h31, 1'b0, 5);
    fork
      begin
        applyStimulus(1, 32'h80, 1'b0, 32'h0);
        applyStimulus(1, 32'h84, 1'b0, 32'h0);
      end
      begin
        applyStimulus(3, 32'hC0, 1'b0, 32'h0);
        applyStimulus(3, 32'hC4, 1'b0, 32'h0);
      end
    join

    $display("[TB] reset during BUSY");
    pushExp(0, 32'h30, 1'b0, 32'h0, 32'h0, 1'b0, 5);
    tbAddr[0] = 32'h30; tbWe[0] = 1'b0; tbWdata[0] = '0; tbReq[0] = 1'b1;
    sawDone = 1'b0;
    for (int c = 0; c < 20 && !sawDone; c++) begin
      @(negedge clk);
      if (gnt_o[0]) sawDone = 1'b1;
    end
    checkOutput("reset_test_grant_seen", 64'(sawDone), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abandon_gnt", 64'(gnt_o), 64'd0);
    checkOutput("abandon_mem_req", 64'(mem_req), 64'd0);
    checkOutput("abandon_done", 64'(done_o), 64'd0);
    rst = 1'b0;
    tbReq[0] = 1'b0;
    void'(expQ.pop_front());
    sawDone = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done_o != '0) sawDone = 1'b1;
    end
    checkOutput("no_done_after_reset", 64'(sawDone), 64'd0);
    pushExp(0, 32'h10, 1'b0, 32'h0, 32'h4, 1'b0, 5);
    applyStimulus(0, 32'h10, 1'b0, 32'h0);

    $display("[TB] stalled memory");
    memStall = 1'b1;
`ifdef ARB_TIMEOUT_EN
    pushExp(1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b1, 15);
    applyStimulus(1, 32'h100, 1'b0, 32'h0);
    memStall = 1'b0;
`else
    pushExp(1, 32'h100, 1'b0, 32'h0, 32'h0, 1'b0, 15);
    tbAddr[1] = 32'h100; tbWe[1] = 1'b0; tbWdata[1] = '0; tbReq[1] = 1'b1;
    sawDone = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_o != '0) sawDone = 1'b1;
    end
    checkOutput("no_done_while_stalled", 64'(sawDone), 64'd0);
    checkOutput("stall_mem_req_held", 64'(mem_req), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tbReq[1] = 1'b0;
    memStall = 1'b0;
    void'(expQ.pop_front());
`endif

    repeat (5) @(negedge clk);
    checkOutput("queue_empty", 64'(expQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule
